// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_DATA_WIDTH = 8;

   // Minimum of 1 so a degenerate parameter never yields a zero-width vector.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((32'sd1 <<< r) < value) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer/FIFO write-port bundle seen by the arbiter.
interface fifo_write_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

   localparam int OWNER_W = clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            ack;
   logic                          fifo_full;
   logic                          write_en;
   logic [DATA_WIDTH-1:0]         wr_data;
   logic [OWNER_W-1:0]            owner_id;
   logic                          busy;

   modport master (
      output req, req_data, req_last, fifo_full,
      input  ack, write_en, wr_data, owner_id, busy
   );

   modport slave (
      input  req, req_data, req_last, fifo_full,
      output ack, write_en, wr_data, owner_id, busy
   );

endinterface

// File: rtl/fifo_write_arbiter_rr_priority_picker.sv
// Round-robin search: first requesting index above last_owner, wrapping modulo NUM_REQ.
module rr_priority_picker
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int OWNER_W = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [OWNER_W-1:0] last_owner,
   output logic               found,
   output logic [OWNER_W-1:0] next_owner
);

   int   dist_s;
   int   best_s;
   logic sel_s;

   // Keep the requester with the smallest circular distance past last_owner.
   always_comb begin
      dist_s     = 0;
      best_s     = NUM_REQ;
      sel_s      = 1'b0;
      next_owner = last_owner;
      for (int c = 0; c < NUM_REQ; c++) begin
         dist_s     = (c - int'(last_owner) - 1 + 2 * NUM_REQ) % NUM_REQ;
         sel_s      = req[c] && (dist_s < best_s);
         next_owner = sel_s ? OWNER_W'(c) : next_owner;
         best_s     = sel_s ? dist_s : best_s;
      end
      found = (best_s < NUM_REQ);
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Burst-granting round-robin arbiter for the async FIFO write port.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MAX_BURST  = 8
) (
   input logic                 clk,
   input logic                 reset,
   fifo_write_arbiter_if.slave bus
);

   localparam int OWNER_W = clog2(NUM_REQ);
   localparam int CNT_W   = clog2(MAX_BURST + 1);

   arb_state_e            state_r;
   logic [OWNER_W-1:0]    owner_r;
   logic [CNT_W-1:0]      beat_cnt_r;

   logic                  found_s;
   logic [OWNER_W-1:0]    next_owner_s;
   logic                  req_sel_s;
   logic                  last_sel_s;
   logic [DATA_WIDTH-1:0] data_sel_s;
   logic                  busy_s;
   logic                  beat_s;
   logic                  exit_s;
   logic [NUM_REQ-1:0]    ack_s;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .OWNER_W (OWNER_W)
   ) u_picker (
      .req        (bus.req),
      .last_owner (owner_r),
      .found      (found_s),
      .next_owner (next_owner_s)
   );

   // Owner-indexed muxing and the same-cycle beat handshake.
   always_comb begin
      req_sel_s  = 1'b0;
      last_sel_s = 1'b0;
      data_sel_s = {DATA_WIDTH{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         req_sel_s  = (owner_r == OWNER_W'(i)) ? bus.req[i] : req_sel_s;
         last_sel_s = (owner_r == OWNER_W'(i)) ? bus.req_last[i] : last_sel_s;
         data_sel_s = (owner_r == OWNER_W'(i)) ? bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] : data_sel_s;
      end
      busy_s = (state_r == BURST);
      beat_s = busy_s & req_sel_s & ~bus.fifo_full;
      exit_s = beat_s & (last_sel_s | (beat_cnt_r == CNT_W'(MAX_BURST - 1)));
      ack_s  = {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         ack_s[i] = beat_s & (owner_r == OWNER_W'(i));
      end
   end

   // Outputs derive from reset-cleared state, so they drop as soon as reset asserts.
   assign bus.write_en = beat_s;
   assign bus.ack      = ack_s;
   assign bus.wr_data  = data_sel_s;
   assign bus.owner_id = owner_r;
   assign bus.busy     = busy_s;

   // Grant/burst state machine; stalls simply hold every register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         owner_r    <= OWNER_W'(NUM_REQ - 1);
         beat_cnt_r <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (found_s) begin
                  owner_r    <= next_owner_s;
                  beat_cnt_r <= {CNT_W{1'b0}};
                  state_r    <= BURST;
               end else begin
                  state_r    <= IDLE;
               end
            end
            BURST: begin
               if (beat_s) begin
                  beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                  state_r    <= exit_s ? IDLE : BURST;
               end else begin
                  state_r    <= BURST;
               end
            end
            default: begin
               state_r    <= IDLE;
               beat_cnt_r <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

endmodule
